mod_updown_counter: RTL and testbench

- Parametrised synchronous successor to the 4-bit free-running ripple counter.
- Modulo-N up/down counter with clock enable, parallel load, wrap or saturate mode, terminal-count output, wrap pulse and sticky overflow flag.
- Used as the general-purpose count/timer primitive in the design. Single clock domain; all state updates on posedge clk.

---
 rtl/mod_updown_counter.sv | 86 ++++++++
 tb/tb_mod_updown_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Parametrised modulo-N up/down counter with enable, clamped parallel load,
// wrap or saturate bounds, terminal-count, wrap pulse and sticky overflow.
module mod_updown_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULO   = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam int unsigned EW = WIDTH + 1;
    localparam logic [WIDTH:0] MAX = EW'(MODULO - 1);

    if ((MODULO < 2) || (64'(MODULO) > (64'(1) << WIDTH))) begin : g_bad_modulo
        $error("mod_updown_counter: MODULO out of range for WIDTH");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   lv_ext;
    logic             at_max;
    logic             at_zero;

    // Compare and step in WIDTH+1 bits so a full-range MODULO never depends on rollover
    assign q_ext   = {1'b0, q_q};
    assign lv_ext  = {1'b0, load_val};
    assign at_max  = (q_ext == MAX);
    assign at_zero = (q_ext == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q & ~clr_ovf;
        if (load) begin
            q_d = (lv_ext > MAX) ? WIDTH'(MAX) : load_val;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    q_d    = SATURATE ? q_q : '0;
                    wrap_d = ~SATURATE;
                    ovf_d  = 1'b1;
                end else begin
                    q_d = WIDTH'(q_ext + EW'(1));
                end
            end else begin
                if (at_zero) begin
                    q_d    = SATURATE ? q_q : WIDTH'(MAX);
                    wrap_d = ~SATURATE;
                    ovf_d  = 1'b1;
                end else begin
                    q_d = WIDTH'(q_ext - EW'(1));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;
    assign tc   = en & ~load & ~reset & (up ? at_max : at_zero);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four configurations driven in lockstep and
// compared against an integer-arithmetic reference model.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       clr_ovf = 1'b0;

    wire [3:0] q0, q1, q2;
    wire       q3;
    wire [3:0] tc_v, wrap_v, ovf_v;
    wire [3:0] q_a [4];

    int checks = 0;
    int errors = 0;

    // Per-instance configuration and model state
    int mod_a [4] = '{10, 10, 16, 2};
    int sat_a [4] = '{0, 1, 0, 0};
    int mq [4];
    int mw [4];
    int mo [4];

    always #5 clk = ~clk;

    assign q_a[0] = q0;
    assign q_a[1] = q1;
    assign q_a[2] = q2;
    assign q_a[3] = {3'b000, q3};

    mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .q(q0), .tc(tc_v[0]), .wrap(wrap_v[0]), .ovf(ovf_v[0]));
    mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .q(q1), .tc(tc_v[1]), .wrap(wrap_v[1]), .ovf(ovf_v[1]));
    mod_updown_counter #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) u2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .q(q2), .tc(tc_v[2]), .wrap(wrap_v[2]), .ovf(ovf_v[2]));
    mod_updown_counter #(.WIDTH(1), .MODULO(2), .SATURATE(1'b0)) u3 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[0:0]),
        .clr_ovf(clr_ovf), .q(q3), .tc(tc_v[3]), .wrap(wrap_v[3]), .ovf(ovf_v[3]));

    task automatic chk(input string tag, input int idx, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s inst%0d got %0d exp %0d", tag, idx, got, exp);
        end
    endtask

    // One clock: apply inputs, check tc, advance model at posedge, check registers
    task automatic step(input bit rs, input bit e, input bit u, input bit ld,
                        input int lv, input bit clr);
        reset    = rs;
        en       = e;
        up       = u;
        load     = ld;
        load_val = 4'(lv);
        clr_ovf  = clr;
        #1;
        for (int i = 0; i < 4; i++) begin
            int exp_tc;
            exp_tc = (e && !ld && !rs && (u ? (mq[i] == mod_a[i] - 1) : (mq[i] == 0))) ? 1 : 0;
            chk("tc", i, int'(tc_v[i]), exp_tc);
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            int m, lvi, nq;
            m   = mod_a[i];
            lvi = (i == 3) ? (lv & 1) : (lv & 15);
            mw[i] = 0;
            if (rs) begin
                mq[i] = 0;
                mo[i] = 0;
            end else begin
                if (clr) mo[i] = 0;
                if (ld) begin
                    mq[i] = (lvi > m - 1) ? m - 1 : lvi;
                end else if (e) begin
                    nq = mq[i] + (u ? 1 : -1);
                    if (nq < 0 || nq >= m) begin
                        mo[i] = 1;
                        if (sat_a[i] == 0) begin
                            mq[i] = (nq + m) % m;
                            mw[i] = 1;
                        end
                    end else begin
                        mq[i] = nq;
                    end
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("q", i, int'(q_a[i]), mq[i]);
            chk("wrap", i, int'(wrap_v[i]), mw[i]);
            chk("ovf", i, int'(ovf_v[i]), mo[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mq[i] = 0;
            mw[i] = 0;
            mo[i] = 0;
        end
        @(negedge clk);

        // Reset then a 12-edge up count
        step(1, 0, 0, 0, 0, 0);
        chk("reset_q", 0, int'(q0), 0);
        chk("reset_ovf", 0, int'(ovf_v[0]), 0);
        for (int k = 0; k < 12; k++) step(0, 1, 1, 0, 0, 0);
        chk("up12_q", 0, int'(q0), 2);
        chk("up12_ovf", 0, int'(ovf_v[0]), 1);

        // Load then count down through zero, then clamped load
        step(0, 0, 0, 1, 3, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0, 0);
        chk("down5_q", 0, int'(q0), 8);
        step(0, 0, 0, 1, 12, 0);
        chk("clamp_q", 0, int'(q0), 9);
        chk("clamp_wrap", 0, int'(wrap_v[0]), 0);

        // Saturating instance holds at bounds
        step(0, 0, 0, 1, 8, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 0);
        chk("sat_hi_q", 1, int'(q1), 9);
        chk("sat_hi_wrap", 1, int'(wrap_v[1]), 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("sat_lo_q", 1, int'(q1), 0);

        // ovf clear, then clear colliding with a wrap
        step(0, 0, 0, 0, 0, 1);
        chk("clr_ovf", 0, int'(ovf_v[0]), 0);
        step(0, 0, 0, 1, 9, 0);
        step(0, 1, 1, 0, 0, 1);
        chk("clr_vs_wrap_ovf", 0, int'(ovf_v[0]), 1);
        chk("clr_vs_wrap_q", 0, int'(q0), 0);

        // Priority: load over en, reset over load, hold with en low
        step(0, 0, 0, 1, 7, 0);
        step(0, 1, 1, 1, 5, 0);
        chk("load_over_en", 0, int'(q0), 5);
        step(1, 0, 0, 1, 5, 0);
        chk("reset_over_load", 0, int'(q0), 0);
        step(0, 0, 0, 1, 6, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0, 0);
        chk("hold_q", 0, int'(q0), 6);

        // Full-range and MODULO=2 continuous up count
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 1, 1, 0, 0, 0);
        chk("mod16_q", 2, int'(q2), 4);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(31) == 0), ($urandom_range(3) != 0), 1'($urandom),
                 ($urandom_range(7) == 0), int'($urandom_range(15)),
                 ($urandom_range(7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
